adc_sar_controller: RTL

Successive-approximation control FSM for the 12-bit capacitive SAR ADC. On a start request it runs a sampling phase and then a 12-step binary search. Each step drives a trial code on the 12-bit DAC data bus that feeds the row/column thermometer decoder of the capacitor matrix. The controller decides one bit per cycle from the comparator output and publishes the final code with a one-cycle valid strobe.

---
 rtl/adc_sar_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/adc_sar_controller.sv
// adc_sar_controller: sample-then-binary-search control FSM for the 12-bit SAR ADC.
// The trial code, result and state live in registers, and every output decodes from them.
module adc_sar_controller #(
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        comp_i,
  output logic        sample_o,
  output logic [11:0] dac_data_o,
  output logic        busy_o,
  output logic [11:0] result_o,
  output logic        result_valid_o
);

  // state   | meaning
  // IDLE    | waiting for start_i; last resolved code stays on the DAC bus
  // SAMPLE  | sampling switches closed, DAC at midscale, down-counter running
  // CONVERT | one bit decided per cycle, bit_idx from 11 down to 0
  // DONE    | result published with a one-cycle valid strobe

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]  SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [11:0] MIDSCALE    = 12'h800;
  localparam logic [3:0]  MSB_IDX     = 4'd11;

  state_t      state, next_state;
  logic [3:0]  sample_cnt, next_sample_cnt;
  logic [3:0]  bit_idx, next_bit_idx;
  logic [11:0] code, next_code;
  logic [11:0] result, next_result;
  logic [11:0] bit_mask;
  logic [11:0] kept_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= 4'd0;
      bit_idx    <= MSB_IDX;
      code       <= 12'h000;
      result     <= 12'h000;
    end else begin
      state      <= next_state;
      sample_cnt <= next_sample_cnt;
      bit_idx    <= next_bit_idx;
      code       <= next_code;
      result     <= next_result;
    end
  end

  always_comb begin
    next_state      = state;
    next_sample_cnt = sample_cnt;
    next_bit_idx    = bit_idx;
    next_code       = code;
    next_result     = result;
    sample_o        = 1'b0;
    busy_o          = 1'b1;
    result_valid_o  = 1'b0;

    // Mask-based bit update: clearing a rejected bit can never borrow or wrap.
    bit_mask  = 12'h001 << bit_idx;
    kept_code = comp_i ? code : (code & ~bit_mask);

    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          next_state      = SAMPLE;
          next_sample_cnt = SAMPLE_LOAD;
          next_code       = MIDSCALE;
        end
      end

      SAMPLE: begin
        sample_o = 1'b1;
        if (sample_cnt == 4'd0) begin
          next_state   = CONVERT;
          next_bit_idx = MSB_IDX;
          next_code    = MIDSCALE;
        end else begin
          next_sample_cnt = sample_cnt - 4'd1;
        end
      end

      CONVERT: begin
        if (bit_idx != 4'd0) begin
          next_code    = kept_code | (bit_mask >> 1);
          next_bit_idx = bit_idx - 4'd1;
        end else begin
          next_code   = kept_code;
          next_result = kept_code;
          next_state  = DONE;
        end
      end

      DONE: begin
        result_valid_o = 1'b1;
        next_state     = IDLE;
      end

      default: begin
        busy_o     = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  assign dac_data_o = code;
  assign result_o   = result;

endmodule
